board_row_clear: RTL
====================

// Module: board_row_clear
// PURPOSE
//  Line-clear engine for the 10x20 Tetris board held in processor RAM (one cell/word, row-major, addr = BASE_ADDR + COLS*row + col).
//  - Writer counterpart of the VGA scan-out, which reads the same cells; cell bits [2:0] are the colour code, 0 means empty.
//  - On start, scans rows bottom-up, collapses every full row (rows above move down one, row 0 zero-filled) and reports the count.
//  - Owns the RAM port while busy; the top level muxes its address, write-enable and data onto the board RAM.
// PARAMETERS
//  COLS        10   cells per row
//  ROWS        20   rows on the board
//  BASE_ADDR   0    RAM word address of cell (0,0)
//  ADDR_WIDTH  12   RAM address width
//  DATA_WIDTH  32   RAM word width
// PORTS
//  clock          in   1            system clock; RAM is synchronous on the same edge
//  reset          in   1            asynchronous, active-low reset
//  start          in   1            request a scan/collapse pass; sampled only in IDLE
//  busy           out  1            engine owns the RAM port (mem_req == busy)
//  done           out  1            one-cycle pulse when the pass completes
//  lines_cleared  out  3            full rows removed in the last pass, saturating at 7
//  mem_req        out  1            top level selects the engine's address and data onto the board RAM
//  mem_addr       out  ADDR_WIDTH   RAM address
//  mem_wEn        out  1            RAM write enable
//  mem_dataIn     out  DATA_WIDTH   RAM write data
//  mem_dataOut    in   DATA_WIDTH   RAM read data, valid one cycle after mem_addr
// BEHAVIOUR
//  - Reset: async assert sends the FSM to IDLE; busy, done, mem_req, mem_wEn = 0; mem_addr, mem_dataIn, lines_cleared = 0.
//  - Reset mid-pass: abort at once with no rollback; a partially shifted board is accepted.
//  - States:
//    - IDLE: start=1 -> SCAN; row = ROWS-1; lines_cleared = 0; busy = 1 from the next cycle.
//    - SCAN: issue reads for col 0..COLS-1 of the current row, one per cycle. Track full = AND of (data[2:0] != 0). The decision cycle follows the last return, so each row costs COLS+1 cycles. Then:
//      - full -> SHIFT with dst = row;
//      - not full and row == 0 -> DONE;
//      - otherwise row-1 -> SCAN.
//    - SHIFT: for dst = row down to 1, col = 0..COLS-1: read (dst-1,col), write that word to (dst,col) the next cycle. Two cycles per cell; no overlap of cells.
//    - CLEAR: write 0 to (0,col) for col = 0..COLS-1, one write per cycle. Increment lines_cleared (saturating), then -> SCAN of the same row, because the row above has moved into it.
//    - DONE: done = 1 and busy still 1 for one cycle, then IDLE (busy = 0).
//  - Write data is the full word as read; CLEAR writes all zeros. mem_wEn is high only in SHIFT write cycles and CLEAR cycles.
//  - Timing: start is sampled at cycle 0. A pass with no full rows asserts done at cycle 1 + ROWS*(COLS+1) = 221. A full row r adds 2*COLS*r + COLS + (COLS+1) cycles.
//  - start while busy: ignored, no queueing. start held high across done: a new pass begins on the IDLE cycle that follows.
//  - lines_cleared holds its value from done until the next accepted start.
// CONFIGURATION
//  ROWCLR_SCORE_EN
//  - Defined: adds port score_delta out 11 bits, registered at done and held until the next start.
//    - Value by lines cleared: 0->0, 1->40, 2->100, 3->300, >=4->1200.
//    - Reset value 0.
//  - Undefined: the port and its logic are absent; everything else is identical.
// TESTING
//  1. Empty board, start pulse -> no mem_wEn ever, done at cycle 221, lines_cleared = 0, busy low the cycle after done.
//  2. Row 19 all colour 1; (18,0) = 3, rest empty, start -> (19,0) = 3, (19,1..9) = 0, row 0 = 0, lines_cleared = 1 (score_delta = 40).
//  3. Rows 16..19 all colour 5, rows 0..15 empty -> all 200 cells 0, lines_cleared = 4 (score_delta = 1200).
//  4. Row 19 full except (19,9) = 0 -> RAM unchanged, lines_cleared = 0. Row 0 alone full -> row 0 zeroed, lines_cleared = 1.
//  5. Rows 19 and 17 full, row 18 = colour 2 at col 4 -> after the pass row 19 holds only col 4 = 2, lines_cleared = 2, done at the cycle predicted by the timing rule.
//  6. Second start while busy -> ignored. reset low mid-SHIFT -> busy, done, mem_wEn = 0 immediately; next start runs a clean pass.

Source files
------------

// File: rtl/board_row_clear_if.sv
// Engine-side bundle for board_row_clear: start/status handshake plus the board RAM port.
// With ROWCLR_SCORE_EN defined the bundle also carries score_delta.
`timescale 1ns/1ps
interface board_row_clear_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [2:0]            lines_cleared;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wEn;
  logic [DATA_WIDTH-1:0] mem_dataIn;
  logic [DATA_WIDTH-1:0] mem_dataOut;
`ifdef ROWCLR_SCORE_EN
  logic [10:0]           score_delta;

  modport master (input start, mem_dataOut,
                  output busy, done, lines_cleared, mem_req, mem_addr, mem_wEn, mem_dataIn,
                  score_delta);
  modport slave  (output start, mem_dataOut,
                  input busy, done, lines_cleared, mem_req, mem_addr, mem_wEn, mem_dataIn,
                  score_delta);
`else
  modport master (input start, mem_dataOut,
                  output busy, done, lines_cleared, mem_req, mem_addr, mem_wEn, mem_dataIn);
  modport slave  (output start, mem_dataOut,
                  input busy, done, lines_cleared, mem_req, mem_addr, mem_wEn, mem_dataIn);
`endif
endinterface

// File: rtl/board_row_clear.sv
// board_row_clear: bottom-up line-clear engine for the Tetris board held in RAM.
// Optional ROWCLR_SCORE_EN adds score_delta, the points earned by the last pass.
`timescale 1ns/1ps
module board_row_clear #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  board_row_clear_if.master bus
);
  // state   | meaning
  // S_IDLE  | waiting for start
  // S_SCAN  | reading one row, col_q 0..COLS (last step is the decision)
  // S_SHIFT | copying row dst-1 into row dst, read/write per cell
  // S_CLEAR | zero-filling row 0
  // S_DONE  | one-cycle done pulse
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [RW-1:0] ROW_TOP  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_END  = CW'(COLS);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SHIFT, S_CLEAR, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q, row_d, dst_q, dst_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  full_q, full_d, busy_q, busy_d, done_q, done_d;
  logic                  wen_q, wen_d, copy_q, copy_d;
  logic [2:0]            lines_q, lines_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  cell_ok;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return ADDR_WIDTH'(BASE_ADDR + COLS * 32'(r) + 32'(c));
  endfunction

  assign cell_ok = bus.mem_dataOut[2:0] != 3'd0;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dst_d   = dst_q;
    col_d   = col_q;
    full_d  = full_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wen_d   = 1'b0;
    copy_d  = 1'b0;
    lines_d = lines_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_SCAN;
        row_d   = ROW_TOP;
        col_d   = '0;
        full_d  = 1'b1;
        lines_d = '0;
        busy_d  = 1'b1;
        addr_d  = addr_of(ROW_TOP, '0);
      end
      S_SCAN: begin
        // read data trails the address by one cycle, so col_q=k sees cell k-1
        if (col_q != '0) full_d = full_q & cell_ok;
        if (col_q == COL_END) begin
          col_d = '0;
          if (full_q && cell_ok) begin
            dst_d = row_q;
            if (row_q == '0) begin
              state_d = S_CLEAR;
              wen_d   = 1'b1;
              addr_d  = addr_of('0, '0);
            end else begin
              state_d = S_SHIFT;
              addr_d  = addr_of(row_q - RW'(1), '0);
            end
          end else if (row_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            row_d  = row_q - RW'(1);
            full_d = 1'b1;
            addr_d = addr_of(row_q - RW'(1), '0);
          end
        end else begin
          col_d = col_q + CW'(1);
          if (col_q != COL_LAST) addr_d = addr_of(row_q, col_q + CW'(1));
        end
      end
      S_SHIFT: begin
        if (!copy_q) begin
          // write cycle forwards the returning read word straight to mem_dataIn
          wen_d  = 1'b1;
          copy_d = 1'b1;
          addr_d = addr_of(dst_q, col_q);
        end else if (col_q != COL_LAST) begin
          col_d  = col_q + CW'(1);
          addr_d = addr_of(dst_q - RW'(1), col_q + CW'(1));
        end else if (dst_q != RW'(1)) begin
          dst_d  = dst_q - RW'(1);
          col_d  = '0;
          addr_d = addr_of(dst_q - RW'(2), '0);
        end else begin
          state_d = S_CLEAR;
          col_d   = '0;
          wen_d   = 1'b1;
          addr_d  = addr_of('0, '0);
        end
      end
      S_CLEAR: begin
        if (col_q != COL_LAST) begin
          col_d  = col_q + CW'(1);
          wen_d  = 1'b1;
          addr_d = addr_of('0, col_q + CW'(1));
        end else begin
          state_d = S_SCAN;
          col_d   = '0;
          full_d  = 1'b1;
          lines_d = (lines_q == 3'd7) ? lines_q : lines_q + 3'd1;
          addr_d  = addr_of(row_q, '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      copy_q  <= 1'b0;
      lines_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      copy_q  <= copy_d;
      lines_q <= lines_d;
      addr_q  <= addr_d;
    end
  end

  assign wdata             = copy_q ? bus.mem_dataOut : '0;
  assign bus.busy          = busy_q;
  assign bus.mem_req       = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lines_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wEn       = wen_q;
  assign bus.mem_dataIn    = wdata;

`ifdef ROWCLR_SCORE_EN
  logic [10:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (state_q == S_IDLE && bus.start) score_d = '0;
    else if (done_d) begin
      unique case (lines_q)
        3'd0:    score_d = 11'd0;
        3'd1:    score_d = 11'd40;
        3'd2:    score_d = 11'd100;
        3'd3:    score_d = 11'd300;
        default: score_d = 11'd1200;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) score_q <= '0;
    else        score_q <= score_d;
  end

  assign bus.score_delta = score_q;
`else
  // scoring disabled: no score_delta port or state
`endif
endmodule
